// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision), two
// combinational read ports with optional write bypass, and a busy scoreboard.

module regfile_mp_rdport #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic [AW-1:0] i_ra,
  input  logic [DW-1:0] i_q,
  input  logic          i_bsy,
  input  logic          i_we0,
  input  logic [AW-1:0] i_wa0,
  input  logic [DW-1:0] i_wd0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_wa1,
  input  logic [DW-1:0] i_wd1,
  output logic [DW-1:0] o_rd,
  output logic          o_busy
);
  always_comb begin
    o_rd = i_q;
    // Bypass priority mirrors write priority: port 1 first.
    if (BYPASS != 0 && i_we1 && i_wa1 == i_ra)      o_rd = i_wd1;
    else if (BYPASS != 0 && i_we0 && i_wa0 == i_ra) o_rd = i_wd0;
    if (ZERO_R0 != 0 && i_ra == '0)                 o_rd = '0;
  end

  // Registered scoreboard only; same-cycle set/clear is seen next cycle.
  assign o_busy = i_bsy;
endmodule

module regfile_mp #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_addr,
  output logic          busy0,
  output logic          busy1
);
  localparam int DEPTH  = 2**AW;
  localparam int NUM_RP = 2;

  logic [DEPTH-1:0][DW-1:0]  r_mem;
  logic [DEPTH-1:0]          r_busy;
  logic                      w_wr0, w_wr1, w_bset;
  logic [NUM_RP-1:0][AW-1:0] w_ra;
  logic [NUM_RP-1:0][DW-1:0] w_q, w_rd;
  logic [NUM_RP-1:0]         w_bq, w_busy;

  // Register 0 is never written or claimed when hardwired to zero.
  assign w_wr0  = we0      && !(ZERO_R0 != 0 && wa0 == '0);
  assign w_wr1  = we1      && !(ZERO_R0 != 0 && wa1 == '0);
  assign w_bset = busy_set && !(ZERO_R0 != 0 && busy_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem  <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr0) r_mem[wa0] <= wd0;
      if (w_wr1) r_mem[wa1] <= wd1;
      if (we0)   r_busy[wa0] <= 1'b0;
      if (we1)   r_busy[wa1] <= 1'b0;
      // A new claim outranks the retiring producer's clear.
      if (w_bset) r_busy[busy_addr] <= 1'b1;
    end
  end

  assign w_ra = {ra1, ra0};

  for (genvar g = 0; g < NUM_RP; g++) begin : g_rp
    assign w_q[g]  = r_mem[w_ra[g]];
    assign w_bq[g] = r_busy[w_ra[g]];
    regfile_mp_rdport #(
      .DW(DW), .AW(AW), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
    ) u_rp (
      .i_ra  (w_ra[g]),
      .i_q   (w_q[g]),
      .i_bsy (w_bq[g]),
      .i_we0 (we0),
      .i_wa0 (wa0),
      .i_wd0 (wd0),
      .i_we1 (we1),
      .i_wa1 (wa1),
      .i_wd1 (wd1),
      .o_rd  (w_rd[g]),
      .o_busy(w_busy[g])
    );
  end

  assign rd0   = w_rd[0];
  assign rd1   = w_rd[1];
  assign busy0 = w_busy[0];
  assign busy1 = w_busy[1];
endmodule
